// File: rtl/chaser_pkg.sv
// Shared constants and types for the 7-segment fading chaser.
// Used by the input conditioner and the chaser core.
package chaser_pkg;

    localparam int SPEED_W   = 3;
    localparam int NUM_IN_CH = 4;

    localparam int CH_SPEED0 = 0;
    localparam int CH_SPEED1 = 1;
    localparam int CH_SPEED2 = 2;
    localparam int CH_DIR    = 3;

    localparam int DEBOUNCE_CYCLES_DEF = 1000;

    typedef struct packed {
        logic [SPEED_W-1:0] speed;
        logic               dir;
    } chaser_cfg_t;

endpackage

// File: rtl/chaser_debounce_ch.sv
// One switch channel: 2-flop synchroniser, debounce counter, stable level.
// o_commit pulses (combinationally) in the cycle the stable level takes o_sync.
module chaser_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rst_level,
    input  logic i_raw,
    output logic o_sync,
    output logic o_commit
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          w_differ;
    logic          w_commit;

    assign w_differ = (r_s2 != r_stable);
    assign w_commit = w_differ && (r_cnt == CNT_LAST);

    // bring the asynchronous switch into the clk domain
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1 <= i_rst_level;
            r_s2 <= i_rst_level;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    // accept a new level only after an unbroken run of disagreement
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_stable <= i_rst_level;
        end else if (!w_differ) begin
            r_cnt    <= '0;
        end else if (w_commit) begin
            r_stable <= r_s2;
            r_cnt    <= '0;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign o_sync   = r_s2;
    assign o_commit = w_commit;

endmodule

// File: rtl/chaser_input_conditioner.sv
// Switch front end for the chaser: sync + debounce on 4 inputs.
// Optional macro DIR_TOGGLE_EN: direction toggles on each debounced press.
module chaser_input_conditioner
    import chaser_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEF,
    parameter bit ACTIVE_LOW_SPEED = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SPEED_W-1:0] sw_speed_raw,
    input  logic               sw_dir_raw,
    output logic [SPEED_W-1:0] speed_prefix,
    output logic               direction,
    output logic               cfg_changed
);

    localparam logic SPD_IDLE = ACTIVE_LOW_SPEED ? 1'b1 : 1'b0;

    logic [NUM_IN_CH-1:0] w_raw;
    logic [NUM_IN_CH-1:0] w_sync;
    logic [NUM_IN_CH-1:0] w_commit;

    chaser_cfg_t r_cfg;
    chaser_cfg_t w_cfg_next;
    logic        r_cfg_changed;

    for (genvar g = 0; g < SPEED_W; g++) begin : g_spd_map
        assign w_raw[CH_SPEED0+g] = sw_speed_raw[g];
    end
    assign w_raw[CH_DIR] = sw_dir_raw;

    for (genvar g = 0; g < NUM_IN_CH; g++) begin : g_ch
        localparam logic RST_LVL = (g == CH_DIR) ? 1'b0 : SPD_IDLE;
        chaser_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .i_clk       (clk),
            .i_rst       (reset),
            .i_rst_level (RST_LVL),
            .i_raw       (w_raw[g]),
            .o_sync      (w_sync[g]),
            .o_commit    (w_commit[g])
        );
    end

    // next output values, folded in on the same edge the channel commits
    always_comb begin
        w_cfg_next = r_cfg;
        for (int i = 0; i < SPEED_W; i++) begin
            if (w_commit[CH_SPEED0+i])
                w_cfg_next.speed[i] = w_sync[CH_SPEED0+i] ^ ACTIVE_LOW_SPEED;
        end
`ifdef DIR_TOGGLE_EN
        if (w_commit[CH_DIR] && w_sync[CH_DIR])
            w_cfg_next.dir = ~r_cfg.dir;
`else
        if (w_commit[CH_DIR])
            w_cfg_next.dir = w_sync[CH_DIR];
`endif
    end

    // registered outputs and the one-cycle change strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cfg         <= '0;
            r_cfg_changed <= 1'b0;
        end else begin
            r_cfg         <= w_cfg_next;
            r_cfg_changed <= (w_cfg_next != r_cfg);
        end
    end

    assign speed_prefix = r_cfg.speed;
    assign direction    = r_cfg.dir;
    assign cfg_changed  = r_cfg_changed;

endmodule

// File: tb/tb_chaser_input_conditioner.sv
// Bench for chaser_input_conditioner (DEBOUNCE_CYCLES=4, active-low speed).
// Directed scenarios plus randomized switching against a reference model.
module tb_chaser_input_conditioner;
    import chaser_pkg::*;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] sw_speed_raw = 3'b111;
    logic       sw_dir_raw = 1'b1;
    logic [2:0] speed_prefix;
    logic       direction;
    logic       cfg_changed;

    int n_run  = 0;
    int n_fail = 0;

    // reference model state
    logic [3:0] m_pipe[$];
    logic [3:0] m_stab;
    int         m_run[4];
    logic [2:0] m_prefix;
    logic       m_dir;
    logic       m_cfg;

    chaser_input_conditioner #(
        .DEBOUNCE_CYCLES  (D),
        .ACTIVE_LOW_SPEED (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_speed_raw (sw_speed_raw),
        .sw_dir_raw   (sw_dir_raw),
        .speed_prefix (speed_prefix),
        .direction    (direction),
        .cfg_changed  (cfg_changed)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pipe = {4'b0111, 4'b0111};
        m_stab = 4'b0111;
        foreach (m_run[i]) m_run[i] = 0;
        m_prefix = 3'b000;
        m_dir = 1'b0;
        m_cfg = 1'b0;
    endtask

    // A level is accepted once the two-edge-delayed switch value has
    // disagreed with the accepted level on D consecutive edges.
    task automatic model_edge();
        logic [3:0] seen;
        logic [3:0] acc;
        logic [2:0] np;
        logic       nd;
        seen = m_pipe.pop_front();
        m_pipe.push_back({sw_dir_raw, sw_speed_raw});
        acc = '0;
        for (int ch = 0; ch < 4; ch++) begin
            if (seen[ch] !== m_stab[ch]) begin
                m_run[ch] = m_run[ch] + 1;
                if (m_run[ch] == D) begin
                    m_stab[ch] = seen[ch];
                    m_run[ch] = 0;
                    acc[ch] = 1'b1;
                end
            end else begin
                m_run[ch] = 0;
            end
        end
        np = ~m_stab[2:0];
`ifdef DIR_TOGGLE_EN
        nd = (acc[3] && m_stab[3]) ? ~m_dir : m_dir;
`else
        nd = m_stab[3];
`endif
        m_cfg = (np != m_prefix) || (nd != m_dir);
        m_prefix = np;
        m_dir = nd;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_run++;
        if (speed_prefix !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_speed: got %b expected 000", speed_prefix);
        end
        n_run++;
        if (direction !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dir: got %b expected 0", direction);
        end
        n_run++;
        if (cfg_changed !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cfg: got %b expected 0", cfg_changed);
        end
    endtask

    task automatic test_speed_change();
        logic [2:0] ep;
        logic       ec;
        reset = 1'b0;
        sw_speed_raw = 3'b010;
        sw_dir_raw = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            ep = (e >= 6) ? 3'b101 : 3'b000;
            ec = (e == 6);
            n_run++;
            if (speed_prefix !== ep) begin
                n_fail++;
                $display("FAIL speed_edge%0d: got %b expected %b", e, speed_prefix, ep);
            end
            n_run++;
            if (cfg_changed !== ec) begin
                n_fail++;
                $display("FAIL speed_cfg_edge%0d: got %b expected %b", e, cfg_changed, ec);
            end
        end
    endtask

    task automatic test_glitch();
        for (int b = 0; b < 3; b++) begin
            sw_speed_raw[b] = ~sw_speed_raw[b];
            for (int e = 1; e <= 8; e++) begin
                if (e == 4) sw_speed_raw[b] = ~sw_speed_raw[b];
                tick();
                n_run++;
                if (speed_prefix !== 3'b101 || cfg_changed !== 1'b0) begin
                    n_fail++;
                    $display("FAIL glitch_bit%0d_edge%0d: got %b/%b expected 101/0",
                             b, e, speed_prefix, cfg_changed);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] ep;
        logic       ed;
        logic       ec;
        sw_speed_raw = 3'b101;
        sw_dir_raw = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            ep = (e >= 6) ? 3'b010 : 3'b101;
            ed = (e >= 6);
            ec = (e == 6);
            n_run++;
            if ({speed_prefix, direction, cfg_changed} !== {ep, ed, ec}) begin
                n_fail++;
                $display("FAIL simul_edge%0d: got %b/%b/%b expected %b/%b/%b",
                         e, speed_prefix, direction, cfg_changed, ep, ed, ec);
            end
        end
    endtask

    task automatic test_reset_midcount();
        logic [2:0] ep;
        logic       ed;
        logic       ec;
        sw_speed_raw = 3'b000;
        for (int e = 1; e <= 4; e++) tick();
        n_run++;
        if (speed_prefix !== 3'b010 || cfg_changed !== 1'b0) begin
            n_fail++;
            $display("FAIL midcount_hold: got %b/%b expected 010/0",
                     speed_prefix, cfg_changed);
        end
        reset = 1'b1;
        #2;
        n_run++;
        if ({speed_prefix, direction, cfg_changed} !== 5'b00000) begin
            n_fail++;
            $display("FAIL async_reset: got %b/%b/%b expected 000/0/0",
                     speed_prefix, direction, cfg_changed);
        end
        tick();
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            ep = (e >= 6) ? 3'b111 : 3'b000;
            ed = (e >= 6);
            ec = (e == 6);
            n_run++;
            if ({speed_prefix, direction, cfg_changed} !== {ep, ed, ec}) begin
                n_fail++;
                $display("FAIL post_reset_edge%0d: got %b/%b/%b expected %b/%b/%b",
                         e, speed_prefix, direction, cfg_changed, ep, ed, ec);
            end
        end
    endtask

`ifdef DIR_TOGGLE_EN
    task automatic test_toggle();
        logic before;
        logic after;
        logic press;
        logic ed;
        logic ec;
        reset = 1'b1;
        sw_speed_raw = 3'b111;
        sw_dir_raw = 1'b0;
        tick();
        reset = 1'b0;
        before = 1'b0;
        for (int p = 0; p < 4; p++) begin
            press = (p % 2 == 0);
            after = press ? ~before : before;
            sw_dir_raw = press;
            for (int e = 1; e <= 8; e++) begin
                tick();
                ed = (e >= 6) ? after : before;
                ec = press && (e == 6);
                n_run++;
                if (direction !== ed || cfg_changed !== ec) begin
                    n_fail++;
                    $display("FAIL toggle_p%0d_edge%0d: got %b/%b expected %b/%b",
                             p, e, direction, cfg_changed, ed, ec);
                end
            end
            before = after;
        end
    endtask
`endif

    task automatic test_random();
        int         hold;
        int         r;
        logic [3:0] v;
        hold = 0;
        for (int c = 0; c < 400; c++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                reset = 1'b1;
                model_reset();
                #2;
                n_run++;
                if ({speed_prefix, direction, cfg_changed} !== {m_prefix, m_dir, m_cfg}) begin
                    n_fail++;
                    $display("FAIL rand_reset_c%0d: got %b/%b/%b expected %b/%b/%b",
                             c, speed_prefix, direction, cfg_changed,
                             m_prefix, m_dir, m_cfg);
                end
                reset = 1'b0;
            end
            if (hold == 0) begin
                if (r < 50) begin
                    v = 4'($urandom);
                    {sw_dir_raw, sw_speed_raw} = v;
                end else begin
                    v = {sw_dir_raw, sw_speed_raw};
                    v[$urandom_range(0, 3)] ^= 1'b1;
                    {sw_dir_raw, sw_speed_raw} = v;
                end
                hold = $urandom_range(1, 9);
            end
            hold--;
            tick();
            n_run++;
            if (speed_prefix !== m_prefix) begin
                n_fail++;
                $display("FAIL rand_speed_c%0d: got %b expected %b", c, speed_prefix, m_prefix);
            end
            n_run++;
            if (direction !== m_dir) begin
                n_fail++;
                $display("FAIL rand_dir_c%0d: got %b expected %b", c, direction, m_dir);
            end
            n_run++;
            if (cfg_changed !== m_cfg) begin
                n_fail++;
                $display("FAIL rand_cfg_c%0d: got %b expected %b", c, cfg_changed, m_cfg);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_speed_change();
        test_glitch();
        test_simultaneous();
        test_reset_midcount();
`ifdef DIR_TOGGLE_EN
        test_toggle();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
